run_pattern_detector: RTL and testbench

//  Parametrised run-length pattern detector. Sub-pattern A = exactly N1 consecutive 1s, then exactly N0 consecutive 0s.

---
 rtl/run_det_pkg.sv | 20 ++
 rtl/sat_counter.sv | 36 +++
 rtl/run_pattern_detector.sv | 174 +++++++++++++++++
 tb/tb_run_pattern_detector.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/run_det_pkg.sv
// rtl/run_det_pkg.sv - shared types, default widths and config clamp for the run pattern detector
package run_det_pkg;

   localparam int NW_DEF = 6;
   localparam int MW_DEF = 5;
   localparam int CW_DEF = 16;

   typedef enum logic [1:0] {
      ST_GAP   = 2'd0,
      ST_HUNT  = 2'd1,
      ST_ONES  = 2'd2,
      ST_ZEROS = 2'd3
   } state_e;

   // A zero length or repeat count is meaningless, so it is treated as 1.
   function automatic logic [31:0] clamp_to_one(input logic [31:0] v);
      return (v == 32'd0) ? 32'd1 : v;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear has priority; increment stops at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/run_pattern_detector.sv
// rtl/run_pattern_detector.sv - detects M back-to-back (N1 ones, N0 zeros) runs on a qualified serial stream
module run_pattern_detector
   import run_det_pkg::*;
#(
   parameter int NW = NW_DEF,
   parameter int MW = MW_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_vld,
   input  logic          data_in,
   input  logic          cfg_ld,
   input  logic [NW-1:0] cfg_n1,
   input  logic [NW-1:0] cfg_n0,
   input  logic [MW-1:0] cfg_m,
   input  logic          cfg_chain,
   output logic          dec_pulse,
   output logic [MW-1:0] rep_cnt,
   output logic [CW-1:0] det_cnt
);

   state_e        state_q, state_d;
   logic [NW-1:0] cnt_q, cnt_d;
   logic [MW-1:0] rep_q, rep_d;
   logic          dec_pulse_q, dec_pulse_d;
   logic [NW-1:0] n1_q, n1_d;
   logic [NW-1:0] n0_q, n0_d;
   logic [MW-1:0] m_q, m_d;
   logic          chain_q, chain_d;

   logic [MW-1:0] rep_inc;
   logic          a_done;
   logic          detect;

   // State, run counter, repeat count, pulse and shadow config registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_GAP;
         cnt_q       <= '0;
         rep_q       <= '0;
         dec_pulse_q <= 1'b0;
         n1_q        <= NW'(1);
         n0_q        <= NW'(1);
         m_q         <= MW'(1);
         chain_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rep_q       <= rep_d;
         dec_pulse_q <= dec_pulse_d;
         n1_q        <= n1_d;
         n0_q        <= n0_d;
         m_q         <= m_d;
         chain_q     <= chain_d;
      end
   end

   // Next-state: config load aborts everything, otherwise walk the run FSM on each valid sample.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rep_d       = rep_q;
      n1_d        = n1_q;
      n0_d        = n0_q;
      m_d         = m_q;
      chain_d     = chain_q;
      a_done      = 1'b0;
      detect      = 1'b0;
      rep_inc     = rep_q + 1'b1;

      if (cfg_ld) begin
         n1_d    = NW'(clamp_to_one(32'(cfg_n1)));
         n0_d    = NW'(clamp_to_one(32'(cfg_n0)));
         m_d     = MW'(clamp_to_one(32'(cfg_m)));
         chain_d = cfg_chain;
         state_d = ST_GAP;
         cnt_d   = '0;
         rep_d   = '0;
      end else if (in_vld) begin
         case (state_q)
            ST_GAP: begin
               if (data_in) begin
                  state_d = ST_ONES;
                  cnt_d   = NW'(1);
               end
            end
            ST_HUNT: begin
               // Sitting out an over-long 1-run; only a 0 ends it.
               if (!data_in) begin
                  state_d = ST_GAP;
                  cnt_d   = '0;
               end
            end
            ST_ONES: begin
               if (data_in) begin
                  if (cnt_q < n1_q) begin
                     cnt_d = cnt_q + 1'b1;
                  end else begin
                     state_d = ST_HUNT;
                     rep_d   = '0;
                  end
               end else if (cnt_q >= n1_q) begin
                  state_d = ST_ZEROS;
                  cnt_d   = NW'(1);
                  a_done  = (n0_q == NW'(1));
               end else begin
                  state_d = ST_GAP;
                  cnt_d   = '0;
                  rep_d   = '0;
               end
            end
            ST_ZEROS: begin
               if (!data_in) begin
                  if (cnt_q < n0_q) begin
                     cnt_d  = cnt_q + 1'b1;
                     a_done = ((cnt_q + 1'b1) == n0_q);
                  end else begin
                     state_d = ST_GAP;
                     cnt_d   = '0;
                     rep_d   = '0;
                  end
               end else begin
                  state_d = ST_ONES;
                  cnt_d   = NW'(1);
                  if (cnt_q != n0_q) begin
                     rep_d = '0;
                  end
               end
            end
            default: begin
               state_d = ST_GAP;
               cnt_d   = '0;
               rep_d   = '0;
            end
         endcase

         if (a_done) begin
            if (rep_inc == m_q) begin
               detect = 1'b1;
               if (chain_q) begin
                  // Keep M-1 credited so the very next complete A fires again.
                  rep_d = MW'(m_q - 1'b1);
               end else begin
                  rep_d   = '0;
                  state_d = ST_GAP;
                  cnt_d   = '0;
               end
            end else begin
               rep_d = rep_inc;
            end
         end
      end

      dec_pulse_d = detect;
   end

   // Outputs come straight from registers.
   always_comb begin
      dec_pulse = dec_pulse_q;
      rep_cnt   = rep_q;
   end

   sat_counter #(
      .W (CW)
   ) u_det_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cfg_ld),
      .inc   (detect),
      .cnt   (det_cnt)
   );

endmodule

// File: tb/tb_run_pattern_detector.sv
// tb/tb_run_pattern_detector.sv - directed vector bench for run_pattern_detector
module tb_run_pattern_detector;

   localparam int NW = 6;
   localparam int MW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_vld;
   logic          data_in;
   logic          cfg_ld;
   logic [NW-1:0] cfg_n1;
   logic [NW-1:0] cfg_n0;
   logic [MW-1:0] cfg_m;
   logic          cfg_chain;
   logic          dec_pulse;
   logic [MW-1:0] rep_cnt;
   logic [CW-1:0] det_cnt;

   always #5 clk = ~clk;

   run_pattern_detector #(
      .NW (NW),
      .MW (MW),
      .CW (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vld    (in_vld),
      .data_in   (data_in),
      .cfg_ld    (cfg_ld),
      .cfg_n1    (cfg_n1),
      .cfg_n0    (cfg_n0),
      .cfg_m     (cfg_m),
      .cfg_chain (cfg_chain),
      .dec_pulse (dec_pulse),
      .rep_cnt   (rep_cnt),
      .det_cnt   (det_cnt)
   );

   typedef struct {
      logic          ld;
      logic [NW-1:0] n1;
      logic [NW-1:0] n0;
      logic [MW-1:0] m;
      logic          chain;
      logic          vld;
      logic          din;
      logic          exp_dec;
      logic [MW-1:0] exp_rep;
      logic [CW-1:0] exp_det;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic d, input logic [MW-1:0] r, input logic [CW-1:0] c);
      chk({tag, " dec_pulse"}, 32'(dec_pulse), 32'(d));
      chk({tag, " rep_cnt"}, 32'(rep_cnt), 32'(r));
      chk({tag, " det_cnt"}, 32'(det_cnt), 32'(c));
   endtask

   // One clock: inputs change on the falling edge, outputs are looked at 1ns after the rising edge.
   task automatic drive(input logic ld, input logic [NW-1:0] n1, input logic [NW-1:0] n0,
                        input logic [MW-1:0] m, input logic ch, input logic v, input logic d);
      @(negedge clk);
      cfg_ld    = ld;
      cfg_n1    = n1;
      cfg_n0    = n0;
      cfg_m     = m;
      cfg_chain = ch;
      in_vld    = v;
      data_in   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input int n1, input int n0, input int m, input int ch);
      drive(1'b1, NW'(n1), NW'(n0), MW'(m), ch[0], 1'b1, 1'b1);
      cfg_ld = 1'b0;
   endtask

   task automatic do_bit(input logic v, input logic d);
      drive(1'b0, '0, '0, '0, 1'b0, v, d);
   endtask

   task automatic add_cfg(input int n1, input int n0, input int m, input int ch);
      vec_t r;
      r.ld = 1'b1; r.n1 = NW'(n1); r.n0 = NW'(n0); r.m = MW'(m); r.chain = ch[0];
      r.vld = 1'b1; r.din = 1'b1; r.exp_dec = 1'b0; r.exp_rep = '0; r.exp_det = '0;
      vecs.push_back(r);
   endtask

   // bits / reps / decs / dets are equal-length digit strings, one char per valid sample.
   task automatic add_seq(input string bits, input string reps, input string decs, input string dets);
      vec_t r;
      for (int i = 0; i < bits.len(); i++) begin
         r.ld = 1'b0; r.n1 = '0; r.n0 = '0; r.m = '0; r.chain = 1'b0; r.vld = 1'b1;
         r.din     = (bits[i] == 8'h31);
         r.exp_rep = MW'(reps[i] - 8'h30);
         r.exp_dec = (decs[i] == 8'h31);
         r.exp_det = CW'(dets[i] - 8'h30);
         vecs.push_back(r);
      end
   endtask

   initial begin
      string s;
      rst_n = 1'b0; in_vld = 1'b0; data_in = 1'b0; cfg_ld = 1'b0;
      cfg_n1 = '0; cfg_n0 = '0; cfg_m = '0; cfg_chain = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 1'b0, '0, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // M=3 plain
      add_cfg(2, 2, 3, 0);
      add_seq("110011001100", "000111122220", "000000000001", "000000000001");
      // over-long leading 1-run is skipped
      add_cfg(2, 2, 2, 0);
      add_seq("1110011001100", "0000000011110", "0000000000001", "0000000000001");
      // extra 0 breaks the sequence
      add_cfg(2, 2, 2, 0);
      add_seq("1100011001100", "0001000011110", "0000000000001", "0000000000001");
      // chain mode refires on every further A
      add_cfg(1, 1, 2, 1);
      add_seq("10101010", "01111111", "00010101", "00011223");
      // reload mid-sequence clears rep and det, then needs M fresh A's
      add_cfg(2, 2, 2, 0);
      add_seq("11001100", "00011110", "00000001", "00000001");
      add_seq("1100", "0001", "0000", "1111");
      add_cfg(2, 2, 2, 0);
      add_seq("11001100", "00011110", "00000001", "00000001");
      // m=0 behaves as m=1
      add_cfg(2, 2, 0, 0);
      add_seq("11001100", "00000000", "00010001", "00011112");
      // all-zero config behaves as 1/1/1
      add_cfg(0, 0, 0, 0);
      add_seq("1010", "0000", "0101", "0112");

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].ld, vecs[i].n1, vecs[i].n0, vecs[i].m, vecs[i].chain, vecs[i].vld, vecs[i].din);
         check_outs($sformatf("vec%0d", i), vecs[i].exp_dec, vecs[i].exp_rep, vecs[i].exp_det);
      end

      // Idle cycles between every sample change nothing but timing.
      begin
         string bits = "11001100";
         string reps = "00011110";
         do_cfg(2, 2, 2, 0);
         for (int i = 0; i < bits.len(); i++) begin
            do_bit(1'b1, bits[i] == 8'h31);
            check_outs($sformatf("gap_v%0d", i), i == 7, MW'(reps[i] - 8'h30), CW'(i == 7));
            do_bit(1'b0, bits[i] != 8'h31);
            check_outs($sformatf("gap_i%0d", i), 1'b0, MW'(reps[i] - 8'h30), CW'(i == 7));
         end
      end

      // A load landing on the completing sample wins: no pulse, counts cleared.
      do_cfg(2, 2, 1, 0);
      s = "1100";
      for (int i = 0; i < 4; i++) do_bit(1'b1, s[i] == 8'h31);
      check_outs("pre_ld_det", 1'b1, '0, CW'(1));
      s = "110";
      for (int i = 0; i < 3; i++) do_bit(1'b1, s[i] == 8'h31);
      drive(1'b1, NW'(2), NW'(2), MW'(1), 1'b0, 1'b1, 1'b0);
      cfg_ld = 1'b0;
      check_outs("ld_vs_done", 1'b0, '0, '0);
      do_bit(1'b1, 1'b0);
      check_outs("ld_vs_done_after", 1'b0, '0, '0);

      // Asynchronous reset mid-A clears outputs immediately and restores default config.
      do_cfg(2, 2, 2, 0);
      s = "1100110";
      for (int i = 0; i < 7; i++) do_bit(1'b1, s[i] == 8'h31);
      chk("pre_rst rep_cnt", 32'(rep_cnt), 32'd1);
      @(negedge clk);
      in_vld = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_outs("async_rst", 1'b0, '0, '0);
      @(negedge clk);
      rst_n = 1'b1;
      do_bit(1'b1, 1'b1);
      check_outs("post_rst_b1", 1'b0, '0, '0);
      do_bit(1'b1, 1'b0);
      check_outs("post_rst_b2", 1'b1, '0, CW'(1));

      // det_cnt sticks at all-ones while pulses keep coming.
      do_cfg(1, 1, 1, 1);
      for (int i = 0; i < 20; i++) begin
         do_bit(1'b1, 1'b1);
         do_bit(1'b1, 1'b0);
      end
      check_outs("saturate", 1'b1, '0, CW'(15));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
